// File: rtl/poli_crc_ctrl_pkg.sv
// Shared POLI type package: register selects, CRC sequencer state, control/status
// field positions and the CRC-32 defaults used by poli_crc_ctrl.
package POLI_types_pkg;

  typedef enum logic [3:0] {
    CRC_CONTROL = 4'd0,
    CRC_STATUS  = 4'd1,
    CRC_INPUT   = 4'd2,
    CRC_OUTPUT  = 4'd3
  } regsel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } crc_state_t;

  localparam int CRC_CTRL_START   = 0;
  localparam int CRC_CTRL_CLEAR   = 1;
  localparam int CRC_CTRL_LEN_LSB = 8;
  localparam int CRC_CTRL_LEN_MSB = 15;

  localparam int CRC_STAT_BUSY    = 0;
  localparam int CRC_STAT_DONE    = 1;
  localparam int CRC_STAT_OVF     = 2;
  localparam int CRC_STAT_EMPTY   = 3;
  localparam int CRC_STAT_FULL    = 4;
  localparam int CRC_STAT_CNT_LSB = 8;
  localparam int CRC_STAT_CNT_MSB = 10;

  localparam int CRC_FIFO_DEPTH = 4;

  localparam logic [31:0] CRC_POLY_DEFAULT = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT_DEFAULT = 32'hFFFFFFFF;

  // Sequencer state and remaining word count, exported for checkers.
  typedef struct packed {
    crc_state_t state;
    logic [8:0] words_left;
  } crc_dbg_t;

endpackage

// File: rtl/poli_crc_ctrl_fifo.sv
// Input word buffer for the CRC unit: small synchronous FIFO with same-cycle
// push/pop (accepted even when full), flush, and full/empty/count flags.
module poli_crc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr];
  // A pop frees the slot the simultaneous push lands in, so full does not block it.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge CLK) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/poli_crc_ctrl.sv
// POLI CRC unit: register decode, input FIFO and a bit-serial MSB-first CRC
// sequencer that consumes a programmed number of words.
module poli_crc_ctrl
  import POLI_types_pkg::*;
#(
  parameter int                   WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] CRC_POLY  = WORD_SIZE'(CRC_POLY_DEFAULT),
  parameter logic [WORD_SIZE-1:0] CRC_INIT  = WORD_SIZE'(CRC_INIT_DEFAULT)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  regsel_t              regsel,
  input  logic                 wen,
  input  logic                 ren,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 crc_irq,
  output crc_dbg_t             dbg
);

  localparam int BW = $clog2(WORD_SIZE);
  localparam int CW = $clog2(CRC_FIFO_DEPTH) + 1;

  crc_state_t           state_q, state_d;
  logic [WORD_SIZE-1:0] crc_q, crc_d;
  logic [WORD_SIZE-1:0] shreg_q, shreg_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic [8:0]           words_left_q, words_left_d;
  logic [7:0]           len_q, len_d;
  logic                 ovf_q;
  logic                 fb;

  logic                 ctrl_wr, in_wr, clear_req, start_req;
  logic [7:0]           wr_len;
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [WORD_SIZE-1:0] fifo_rdata;
  logic [CW-1:0]        fifo_count;
  logic                 busy, done;
  logic [WORD_SIZE-1:0] status;

  assign ctrl_wr   = wen && (regsel == CRC_CONTROL);
  assign in_wr     = wen && (regsel == CRC_INPUT);
  assign clear_req = ctrl_wr && wdata[CRC_CTRL_CLEAR];
  assign start_req = ctrl_wr && wdata[CRC_CTRL_START] && !wdata[CRC_CTRL_CLEAR];
  assign wr_len    = wdata[CRC_CTRL_LEN_MSB:CRC_CTRL_LEN_LSB];

  poli_crc_fifo #(.WIDTH(WORD_SIZE), .DEPTH(CRC_FIFO_DEPTH)) u_fifo (
    .CLK   (CLK),
    .nRST  (nRST),
    .flush (clear_req),
    .push  (in_wr),
    .wdata (wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      crc_q        <= CRC_INIT;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      words_left_q <= '0;
      len_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      words_left_q <= words_left_d;
      len_q        <= len_d;
      if (clear_req)                             ovf_q <= 1'b0;
      else if (in_wr && fifo_full && !fifo_pop)  ovf_q <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    words_left_d = words_left_q;
    len_d        = len_q;
    fifo_pop     = 1'b0;
    fb           = 1'b0;
    case (state_q)
      WAIT: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rdata;
          bitcnt_d = BW'(WORD_SIZE - 1);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        fb       = shreg_q[WORD_SIZE-1] ^ crc_q[WORD_SIZE-1];
        crc_d    = (crc_q << 1) ^ (fb ? CRC_POLY : '0);
        shreg_d  = shreg_q << 1;
        bitcnt_d = bitcnt_q - 1'b1;
        if (bitcnt_q == '0) begin
          words_left_d = words_left_q - 9'd1;
          state_d      = (words_left_q == 9'd1) ? DONE : WAIT;
        end
      end
      default: ;
    endcase
    // Register writes override the sequencer; clear beats start.
    if (clear_req) begin
      state_d  = IDLE;
      crc_d    = CRC_INIT;
      fifo_pop = 1'b0;
    end else if (start_req && (state_q == IDLE || state_q == DONE)) begin
      state_d      = WAIT;
      crc_d        = CRC_INIT;
      len_d        = wr_len;
      words_left_d = (wr_len == 8'd0) ? 9'd256 : {1'b0, wr_len};
    end
  end

  assign busy    = (state_q == WAIT) || (state_q == SHIFT);
  assign done    = (state_q == DONE);
  assign crc_irq = done;
  assign dbg.state      = state_q;
  assign dbg.words_left = words_left_q;

  always_comb begin
    status = '0;
    status[CRC_STAT_BUSY]  = busy;
    status[CRC_STAT_DONE]  = done;
    status[CRC_STAT_OVF]   = ovf_q;
    status[CRC_STAT_EMPTY] = fifo_empty;
    status[CRC_STAT_FULL]  = fifo_full;
    status[CRC_STAT_CNT_MSB:CRC_STAT_CNT_LSB] = fifo_count;
  end

  always_comb begin
    rdata = '0;
    if (ren) begin
      case (regsel)
        CRC_CONTROL: rdata[CRC_CTRL_LEN_MSB:CRC_CTRL_LEN_LSB] = len_q;
        CRC_STATUS:  rdata = status;
        CRC_OUTPUT:  rdata = crc_q;
        default:     rdata = '0;
      endcase
    end
  end

endmodule
